// File: rtl/losowanie_multi.sv
// losowanie_multi -- button-driven draw of DRAWS distinct outcomes out of RANGE.
//
// A free-running counter cycles 0..RANGE-1. A button press latches the counter
// as a candidate. The candidate is then probed against a mask of outcomes
// already drawn this round, one slot per cycle, until a free slot is found.
// The free slot is marked used and reported 1-based on result.
//
// Ports
//   clock          sole clock, rising edge
//   reset_         asynchronous, active-high reset
//   press_         raw button level, synchronous to clock
//   rearm_         single-cycle request to start a new round
//   result         last drawn outcome, 1..RANGE (0 after reset)
//   result_valid_  one-cycle pulse, one cycle after result updates
//   draw_count     draws completed in the current round
//   busy_          high while searching for a free slot
//   done_          high once DRAWS outcomes have been drawn
//
// state  | meaning
// IDLE   | waiting for a press
// SEARCH | probing candidate slots, one per cycle
// DONE   | round complete, presses ignored until rearm_
module losowanie_multi #(
    parameter int WIDTH = 3,
    parameter int RANGE = 6,
    parameter int DRAWS = 3
) (
    input  logic                         clock,
    input  logic                         reset_,
    input  logic                         press_,
    input  logic                         rearm_,
    output logic [WIDTH-1:0]             result,
    output logic                         result_valid_,
    output logic [$clog2(DRAWS+1)-1:0]   draw_count,
    output logic                         busy_,
    output logic                         done_
);

    localparam int CW = $clog2(DRAWS + 1);
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(RANGE - 1);
    localparam logic [CW-1:0]    DRAWS_C = CW'(DRAWS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] cand;
    logic [RANGE-1:0] used;
    logic [RANGE-1:0] cand_onehot;
    logic             cand_used;
    logic             press_prev;
    logic             press_edge;
    logic             hit_q;
    logic [CW-1:0]    count_inc;
    logic             busy_next;
    logic             done_next;

    assign press_edge = press_ & ~press_prev;
    assign count_inc  = draw_count + 1'b1;

    // Decode the candidate against the used mask without indexing by a
    // value that may be wider than the mask needs.
    always_comb begin
        cand_onehot = '0;
        cand_used   = 1'b0;
        for (int i = 0; i < RANGE; i++) begin
            if (cand == WIDTH'(i)) begin
                cand_onehot[i] = 1'b1;
                cand_used      = used[i];
            end
        end
    end

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            counter    <= '0;
            press_prev <= 1'b1;
        end else begin
            counter    <= (counter == LAST) ? '0 : counter + 1'b1;
            press_prev <= press_;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; rearm_ overrides everything, including a coincident press.
    always_comb begin
        state_next = state;
        if (rearm_) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (press_edge) state_next = S_SEARCH;
                S_SEARCH: if (!cand_used)
                              state_next = (count_inc == DRAWS_C) ? S_DONE : S_IDLE;
                S_DONE:   state_next = S_DONE;
                default:  state_next = S_IDLE;
            endcase
        end
    end

    // Output decode of the next state, registered below so busy_/done_ come
    // straight from flops.
    always_comb begin
        busy_next = (state_next == S_SEARCH);
        done_next = (state_next == S_DONE);
    end

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            cand          <= '0;
            used          <= '0;
            result        <= '0;
            hit_q         <= 1'b0;
            result_valid_ <= 1'b0;
            draw_count    <= '0;
            busy_         <= 1'b0;
            done_         <= 1'b0;
        end else begin
            busy_         <= busy_next;
            done_         <= done_next;
            // The pulse trails the result update by one cycle; a rearm in
            // that gap drops it so an aborted round never reports.
            result_valid_ <= hit_q & ~rearm_;
            hit_q         <= 1'b0;
            if (rearm_) begin
                used       <= '0;
                draw_count <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (press_edge) cand <= counter;
                    end
                    S_SEARCH: begin
                        if (cand_used) begin
                            cand <= (cand == LAST) ? '0 : cand + 1'b1;
                        end else begin
                            used       <= used | cand_onehot;
                            result     <= cand + 1'b1;
                            draw_count <= count_inc;
                            hit_q      <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (result_valid_) $display("wynik %d", result);
    end
`endif

endmodule

// File: doc/losowanie_multi.md
LOSOWANIE_MULTI -- requirements
Module: losowanie_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 3: bit width of drawn value and result.
REQ-002 SHALL have parameter RANGE, default 6: number of outcomes, legal 2..2^WIDTH-1.
REQ-003 SHALL have parameter DRAWS, default 3: draws per round without repetition, legal 1..RANGE.
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on posedge.
REQ-005 SHALL have port reset_  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port press_  input  1  raw button level, synchronous to clock.
REQ-007 SHALL have port rearm_  input  1  single-cycle request to start a new round.
REQ-008 SHALL have port result  output  WIDTH  last drawn outcome, 1-based (1..RANGE).
REQ-009 SHALL have port result_valid_  output  1  one-cycle pulse when result updates.
REQ-010 SHALL have port draw_count  output  $clog2(DRAWS+1)  draws completed this round.
REQ-011 SHALL have port busy_  output  1  high while in SEARCH.
REQ-012 SHALL have port done_  output  1  high when draw_count == DRAWS.

Function
REQ-013 SHALL keep a free-running counter 0..RANGE-1, +1 per cycle, RANGE-1 wrapping to 0; rearm_ does not affect it.
REQ-014 SHALL detect a press as press_ high with registered previous press_ low; registered previous press_ resets to 1.
REQ-015 SHALL keep a RANGE-bit used mask, one bit per outcome, cleared by reset and rearm_.
REQ-016 SHALL implement states IDLE, SEARCH, DONE.
REQ-017 IDLE: on a press, SHALL latch candidate = counter value at that edge and enter SEARCH.
REQ-018 SEARCH, candidate unused: SHALL set its used bit, result <= candidate+1, pulse result_valid_ the following cycle, increment draw_count, enter DONE if the new count == DRAWS, else IDLE.
REQ-019 SEARCH, candidate used: SHALL advance candidate by one (RANGE-1 wraps to 0) and remain in SEARCH; at most one probe per cycle.
REQ-020 Latency SHALL be: result_valid_ high 2 cycles after the press edge, plus 1 cycle per used slot probed.
REQ-021 Presses during SEARCH or DONE SHALL be ignored and not queued.
REQ-022 rearm_ in any state SHALL clear used mask and draw_count, abort any search without a result pulse, and enter IDLE next cycle; result holds its value.
REQ-023 rearm_ coincident with a press SHALL take priority; the press is dropped.
REQ-024 result SHALL hold its value between pulses; result_valid_ SHALL never be high two consecutive cycles.
REQ-025 done_ and busy_ SHALL be registered state decodes, glitch-free.
REQ-026 Under simulation, a pulse SHALL $display "wynik %d" with result.

Reset
REQ-027 reset_ high SHALL immediately force: state IDLE, counter 0, used mask 0, result 0, result_valid_ 0, draw_count 0, busy_ 0, done_ 0, previous press_ 1.
REQ-028 Reset asserted mid-SEARCH SHALL discard the search with no result pulse.
REQ-029 A press_ held high across reset release SHALL not trigger a draw until released and pressed again.

Verification (WIDTH=3, RANGE=4, DRAWS=3)
REQ-030 Reset, then idle 10 cycles -> result 0, result_valid_ never high, draw_count 0, done_ 0, busy_ 0.
REQ-031 Press edge with counter=2 -> result_valid_ pulses 2 cycles later, result=3, draw_count=1.
REQ-032 Next press with counter=2 again -> probe 3 free -> result=4, pulse 3 cycles after edge, draw_count=2; then press with counter=3 and slots 2,3 used -> wrap to 0, result=1, done_=1.
REQ-033 Press while done_=1 -> no pulse, draw_count stays 3; rearm_ -> done_ 0, draw_count 0; press with counter=2 -> result=3.
REQ-034 rearm_ on the same cycle as a press edge -> no pulse; asserted in SEARCH -> search aborted, busy_ 0 next cycle, no pulse.
REQ-035 reset_ asserted mid-SEARCH with press_ held high through release -> all outputs at reset values, no pulse until press_ falls and rises again.
